// File: rtl/agc_histogram.sv
// Histogram of the AGC output codes across all lanes over a window of valid beats.
// Latency: beat counted at T shows in the bins at T+3; no back-pressure, one beat per clock.
module agc_histogram #(
  parameter int NSAMP    = 8,
  parameter int NBITS    = 5,
  parameter int CNT_BITS = 24,
  parameter int WIN_BITS = 18
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [NSAMP*NBITS-1:0] dat_i,
  input  logic                   dat_valid_i,
  input  logic                   start_i,
  input  logic [WIN_BITS-1:0]    window_i,
  input  logic [NBITS-1:0]       rd_bin_i,
  output logic [CNT_BITS-1:0]    rd_count_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   sat_o
);

  localparam int NBINS = 1 << NBITS;
  localparam int MW    = $clog2(NSAMP + 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

  state_t                 state_q, state_d;
  logic [WIN_BITS-1:0]    beats_q, beats_d;
  logic                   flush_q, flush_d;
  logic                   s1_vld_q, s1_vld_d;
  logic [NSAMP*NBITS-1:0] s1_dat_q;
  logic                   s2_vld_q;
  logic [MW-1:0]          m_q [NBINS];
  logic [MW-1:0]          m_d [NBINS];
  logic [CNT_BITS-1:0]    cnt_q [NBINS];
  logic [CNT_BITS-1:0]    cnt_d [NBINS];
  logic [NBINS-1:0]       ovf;
  logic                   sat_q;
  logic [CNT_BITS-1:0]    rd_count_q;

  // Beat qualification happens here so the pipeline only carries counted beats.
  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    flush_d  = flush_q;
    s1_vld_d = 1'b0;
    if (start_i) begin
      beats_d = window_i;
      flush_d = 1'b0;
      state_d = (window_i == '0) ? FLUSH : RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (dat_valid_i && beats_q != '0) begin
            s1_vld_d = 1'b1;
            beats_d  = beats_q - WIN_BITS'(1);
            if (beats_q == WIN_BITS'(1)) state_d = FLUSH;
          end
        end
        FLUSH: begin
          flush_d = ~flush_q;
          if (flush_q) state_d = DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      m_d[b] = '0;
      for (int i = 0; i < NSAMP; i++) begin
        m_d[b] = m_d[b] + MW'(s1_dat_q[NBITS*i +: NBITS] == NBITS'(b));
      end
    end
  end

  always_comb begin
    for (int b = 0; b < NBINS; b++) begin
      logic [CNT_BITS:0] sum;
      sum      = {1'b0, cnt_q[b]} + (CNT_BITS+1)'(m_q[b]);
      ovf[b]   = sum[CNT_BITS];
      cnt_d[b] = ovf[b] ? '1 : sum[CNT_BITS-1:0];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= IDLE;
      beats_q    <= '0;
      flush_q    <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      s2_vld_q   <= 1'b0;
      sat_q      <= 1'b0;
      rd_count_q <= '0;
      for (int b = 0; b < NBINS; b++) begin
        m_q[b]   <= '0;
        cnt_q[b] <= '0;
      end
    end else begin
      state_q    <= state_d;
      beats_q    <= beats_d;
      flush_q    <= flush_d;
      s1_vld_q   <= s1_vld_d;
      s1_dat_q   <= dat_i;
      rd_count_q <= cnt_q[rd_bin_i];
      for (int b = 0; b < NBINS; b++) m_q[b] <= m_d[b];
      // A restart drops beats still in flight so partial counts never leak in.
      if (start_i) begin
        s2_vld_q <= 1'b0;
        sat_q    <= 1'b0;
        for (int b = 0; b < NBINS; b++) cnt_q[b] <= '0;
      end else begin
        s2_vld_q <= s1_vld_q;
        if (s2_vld_q) begin
          if (|ovf) sat_q <= 1'b1;
          for (int b = 0; b < NBINS; b++) cnt_q[b] <= cnt_d[b];
        end
      end
    end
  end

  assign rd_count_o = rd_count_q;
  assign busy_o     = (state_q == RUN) || (state_q == FLUSH);
  assign done_o     = (state_q == DONE);
  assign sat_o      = sat_q;

endmodule
